// File: rtl/guess_match_arbiter.sv
// Guess conditioning: 2-flop sync, debounce and arbitrated match strobe
// for the two-timer game core.
module guess_match_arbiter #(
  parameter int WIDTH         = 5,
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = 20,
  parameter int HOLD_MAX      = 8
) (
  input  logic             clk,
  input  logic             button_reset,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] target,
  input  logic             target_valid,
  output logic             match_pulse,
  output logic             match_player,
  output logic [WIDTH-1:0] stable1,
  output logic [WIDTH-1:0] stable2,
  output logic             busy
);

  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state, state_d;

  logic [1:0][WIDTH-1:0] raw;
  logic [1:0][WIDTH-1:0] meta;
  logic [1:0][WIDTH-1:0] sync;
  logic [1:0][WIDTH-1:0] cand;
  logic [1:0][WIDTH-1:0] stab;
  logic [1:0][CNT_W-1:0] cnt;

  logic [1:0] armed;
  logic [1:0] set_arm;
  logic [1:0] clr_arm;
  logic [1:0] hit;

  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [HW-1:0]    hold_cnt, hold_d;
  logic             last_winner, lw_d;
  logic             pulse_d;
  logic             player_d;
  logic             win;

  assign raw = {in2, in1};

  always_ff @(posedge clk or negedge button_reset) begin
    if (!button_reset) begin
      meta <= '0;
      sync <= '0;
      cand <= '0;
      cnt  <= '0;
      stab <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      for (int k = 0; k < 2; k++) begin
        if (sync[k] != cand[k]) begin
          cand[k] <= sync[k];
          cnt[k]  <= '0;
        end else if (cnt[k] < CNT_MAX) begin
          cnt[k] <= cnt[k] + 1'b1;
        end else if (stab[k] != cand[k]) begin
          stab[k] <= cand[k];
        end
      end
    end
  end

  // A fresh settled value re-arms its player; this wins over a same-cycle clear.
  always_comb begin
    set_arm = '0;
    hit     = '0;
    for (int k = 0; k < 2; k++) begin
      set_arm[k] = (sync[k] == cand[k]) && (cnt[k] == CNT_MAX)
                   && (stab[k] != cand[k]);
      hit[k]     = armed[k] && (stab[k] == target);
    end
  end

  always_ff @(posedge clk or negedge button_reset) begin
    if (!button_reset) begin
      armed <= '1;
    end else begin
      armed <= (armed & ~clr_arm) | set_arm;
    end
  end

  always_comb begin
    state_d  = state;
    pulse_d  = 1'b0;
    player_d = match_player;
    tgt_d    = tgt_q;
    hold_d   = hold_cnt;
    lw_d     = last_winner;
    clr_arm  = '0;
    win      = 1'b0;
    unique case (state)
      IDLE: begin
        if (target_valid) state_d = ARMED;
      end
      ARMED: begin
        if (!target_valid) begin
          state_d = IDLE;
        end else if (|hit) begin
          win = (hit == 2'b11) ? ~last_winner : hit[1];
          if (hit == 2'b11) lw_d = win;
          pulse_d  = 1'b1;
          player_d = win;
          clr_arm  = win ? 2'b10 : 2'b01;
          tgt_d    = target;
          hold_d   = '0;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (!target_valid) begin
          state_d = IDLE;
        end else if (target != tgt_q || hold_cnt == HOLD_LAST) begin
          state_d = ARMED;
        end else begin
          hold_d = hold_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge button_reset) begin
    if (!button_reset) begin
      state        <= IDLE;
      match_pulse  <= 1'b0;
      match_player <= 1'b0;
      tgt_q        <= '0;
      hold_cnt     <= '0;
      last_winner  <= 1'b1;
    end else begin
      state        <= state_d;
      match_pulse  <= pulse_d;
      match_player <= player_d;
      tgt_q        <= tgt_d;
      hold_cnt     <= hold_d;
      last_winner  <= lw_d;
    end
  end

  assign stable1 = stab[0];
  assign stable2 = stab[1];
  assign busy    = (state == HOLD);

endmodule

// File: tb/tb_guess_match_arbiter.sv
// Directed bench for guess_match_arbiter with a pulse scoreboard
// and short debounce/hold parameters.
module tb_guess_match_arbiter;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         button_reset;
  logic [W-1:0] in1, in2, target;
  logic         target_valid;
  logic         match_pulse, match_player, busy;
  logic [W-1:0] stable1, stable2;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  guess_match_arbiter #(
    .WIDTH(W), .STABLE_CYCLES(4), .CNT_W(3), .HOLD_MAX(8)
  ) dut (
    .clk(clk),
    .button_reset(button_reset),
    .in1(in1),
    .in2(in2),
    .target(target),
    .target_valid(target_valid),
    .match_pulse(match_pulse),
    .match_player(match_player),
    .stable1(stable1),
    .stable2(stable2),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sb_empty(input string tag);
    #1;
    chk(tag, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (button_reset && match_pulse) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_pulse: observed player %0d expected none",
               match_player);
      end else begin
        chk("sb_player", {31'd0, match_player}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    button_reset = 1'b0;
    in1 = 5'd13; in2 = 5'd0; target = 5'd13; target_valid = 1'b1;
    tick(2);
    chk("rst_pulse", match_pulse, 0);
    chk("rst_player", match_player, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stable1", stable1, 0);
    chk("rst_stable2", stable2, 0);

    // single hit, player 1
    button_reset = 1'b1;
    exp_q.push_back(1'b0);
    tick(6);
    chk("t1_stable1_early", stable1, 0);
    tick(1);
    chk("t1_stable1", stable1, 13);
    chk("t1_no_pulse_yet", match_pulse, 0);
    tick(1);
    chk("t1_pulse", match_pulse, 1);
    chk("t1_player", match_player, 0);
    chk("t1_busy", busy, 1);
    tick(1);
    chk("t1_pulse_one_cycle", match_pulse, 0);

    // hold timeout, then re-arm only by a new settled value
    tick(6);
    chk("t4_busy_last", busy, 1);
    tick(1);
    chk("t4_busy_fall", busy, 0);
    tick(10);
    sb_empty("t4_no_rescore");
    in1 = 5'd12;
    tick(7);
    chk("t4_stable1_12", stable1, 12);
    in1 = 5'd13;
    exp_q.push_back(1'b0);
    tick(7);
    chk("t4_stable1_13", stable1, 13);
    chk("t4_no_pulse_yet", match_pulse, 0);
    tick(1);
    chk("t4_pulse", match_pulse, 1);
    chk("t4_player", match_player, 0);
    tick(10);
    chk("t4_busy_done", busy, 0);
    sb_empty("t4_drained");

    // bouncing player 2 guess
    target = 5'd9;
    for (int i = 0; i < 10; i++) begin
      in2 = (i % 2 == 1) ? 5'd9 : 5'd7;
      tick(2);
      chk("t2_bounce_stable2", stable2, 0);
    end
    exp_q.push_back(1'b1);
    tick(5);
    chk("t2_stable2", stable2, 9);
    chk("t2_no_pulse_yet", match_pulse, 0);
    tick(1);
    chk("t2_pulse", match_pulse, 1);
    chk("t2_player", match_player, 1);
    tick(10);
    chk("t2_busy_done", busy, 0);
    sb_empty("t2_drained");

    // ties alternate, starting with player 1
    target = 5'd21; in1 = 5'd21; in2 = 5'd21;
    exp_q.push_back(1'b0);
    tick(8);
    chk("t3_tie1_pulse", match_pulse, 1);
    chk("t3_tie1_player", match_player, 0);
    target_valid = 1'b0;
    in1 = 5'd3; in2 = 5'd3;
    tick(10);
    chk("t3_stable1_3", stable1, 3);
    chk("t3_stable2_3", stable2, 3);
    in1 = 5'd21; in2 = 5'd21;
    tick(10);
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_no_pulse", match_pulse, 0);
    sb_empty("t5_idle_drained");
    target_valid = 1'b1;
    exp_q.push_back(1'b1);
    tick(1);
    chk("t5_armed_no_pulse", match_pulse, 0);
    tick(1);
    chk("t3_tie2_pulse", match_pulse, 1);
    chk("t3_tie2_player", match_player, 1);
    sb_empty("t3_drained");

    // reset during HOLD
    tick(1);
    chk("t6_in_hold", busy, 1);
    button_reset = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_player", match_player, 0);
    chk("t6_rst_pulse", match_pulse, 0);
    chk("t6_rst_stable1", stable1, 0);
    chk("t6_rst_stable2", stable2, 0);
    tick(1);
    button_reset = 1'b1;
    exp_q.push_back(1'b0);
    tick(7);
    chk("t6_resettle", stable1, 21);
    chk("t6_no_early_pulse", match_pulse, 0);
    tick(1);
    chk("t6_tie_pulse", match_pulse, 1);
    chk("t6_tie_player", match_player, 0);

    // reset mid-debounce
    target = 5'd7; in1 = 5'd7;
    tick(4);
    chk("t6_mid_stable1", stable1, 21);
    button_reset = 1'b0;
    #1;
    chk("t6_mid_rst_stable1", stable1, 0);
    chk("t6_mid_rst_stable2", stable2, 0);
    tick(1);
    button_reset = 1'b1;
    exp_q.push_back(1'b0);
    tick(7);
    chk("t6_mid_stable1_7", stable1, 7);
    chk("t6_mid_stable2_21", stable2, 21);
    chk("t6_mid_no_pulse", match_pulse, 0);
    tick(1);
    chk("t6_mid_pulse", match_pulse, 1);
    chk("t6_mid_player", match_player, 0);

    tick(12);
    sb_empty("final_drained");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
